wb_queue: RTL and testbench
===========================

# wb_queue

Writeback queue between the execute/load stages and the general-purpose register file write port. It accepts results from two producers, the ALU path and the load path, each through a valid/ready handshake. Results are buffered in a small FIFO and drained one per cycle onto the register file's single write port (enable, address, data). It also publishes a per-register pending-write mask for hazard detection upstream.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2
- XLEN, 32, data width

Ports:
- clk1  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result offered
- alu_ready  out  1  ALU result accepted this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_valid  in  1  load result offered
- ld_ready  out  1  load result accepted this cycle
- ld_rd  in  5  load destination register
- ld_data  in  XLEN  load result
- gpr_en  out  1  register-file write enable (registered)
- gpr_addr  out  5  register-file write address (registered)
- gpr_data  out  XLEN  register-file write data (registered)
- pending  out  32  bit r = 1 while a write to register r is queued or being presented
- count  out  log2(DEPTH)+1  FIFO occupancy
- idle  out  1  count==0 and gpr_en==0

## Operation
- Handshake: a transfer occurs on a rising edge where valid && ready. Producers hold rd/data stable while valid is high and not yet accepted.
- Arbitration: at most one enqueue per cycle; the load path has fixed priority.
  - ld_ready = !rst && count<DEPTH
  - alu_ready = !rst && count<DEPTH && !ld_valid
- Ready never depends on the same source's valid.
- rd==0: the handshake completes normally, but the entry is discarded. No enqueue, no count change, no pending bit.
- Dequeue: on each rising edge with count>0, the head entry is popped into gpr_en/gpr_addr/gpr_data, with gpr_en=1. With count==0, gpr_en=0; gpr_addr and gpr_data hold their last values.
- Simultaneous enqueue and dequeue in one edge: count is unchanged and both operations take effect. Ready is computed from count before the edge, so a full FIFO never accepts, even while popping.
- Order: entries drain in acceptance order. Two writes to the same rd reach the write port in order, so the last one wins.
- pending: combinational OR over all valid FIFO entries plus the output register (when gpr_en=1). bit0 is always 0.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty is determined from count, not from pointer equality.

## Timing
- Reset (async assert, sync-safe deassert): the following hold immediately.
  - count=0, pointers=0, gpr_en=0, gpr_addr=0, gpr_data=0
  - pending=0, idle=1, alu_ready=ld_ready=0
- Reset mid-operation: all queued and presented writes are dropped with no partial write.
- Latency: a result accepted at edge N is stored at edge N. If it is the FIFO head, it appears on the port after edge N+1, with gpr_en high for exactly one cycle. The register file commits it at its falling-edge write inside that cycle.
- Throughput: one write per cycle sustained, and one accepted result per cycle when not full.
- pending[r] rises after the accept edge. It falls after the edge where the last write to r leaves the output register.
- count updates on the same edge as the enqueue/dequeue; it is never greater than DEPTH.

## Test plan
- Single ALU write: alu_valid=1, rd=5, data=0x0000_00AA at edge 0 -> pending[5]=1 after edge 0. After edge 1, gpr_en=1, gpr_addr=5, gpr_data=0xAA. After edge 2, gpr_en=0, pending=0, idle=1.
- Priority: ld_valid=1 (rd=3, 0x11) and alu_valid=1 (rd=4, 0x22) together -> ld accepted first with alu_ready=0; ALU accepted next cycle. Port shows rd 3 then rd 4 on consecutive cycles.
- Full/wrap: hold gpr draining, i.e. burst 6 ALU writes rd=1..6 back-to-back with DEPTH=4 from empty.
  - The output stage pops every cycle, so count saturates at no more than 2 and alu_ready stays 1.
  - All 6 writes appear in order; pointers wrap past index 3 with no loss.
- Full boundary (producer burst while ld also pushes): sustain ld_valid and alu_valid every cycle. alu_ready never asserts until ld_valid drops, ld_ready drops only at count==4, and no entry is lost or duplicated.
- rd=0: alu_valid with rd=0, data=0xFFFF_FFFF -> alu_ready=1, count stays 0, gpr_en never rises, pending=0.
- Reset mid-operation: 3 entries queued, rst pulsed asynchronously between edges -> gpr_en=0, count=0, pending=0 immediately. No write appears after reset release.

Source files
------------

// File: rtl/wb_queue_if.sv
// Producer handshakes (ALU and load paths) and the register-file write port.
interface wb_queue_if #(
  parameter int XLEN = 32
);
  logic            alu_valid;
  logic            alu_ready;
  logic [4:0]      alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic            ld_ready;
  logic [4:0]      ld_rd;
  logic [XLEN-1:0] ld_data;
  logic            gpr_en;
  logic [4:0]      gpr_addr;
  logic [XLEN-1:0] gpr_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    input  alu_ready, ld_ready, gpr_en, gpr_addr, gpr_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
    output alu_ready, ld_ready, gpr_en, gpr_addr, gpr_data
  );
endinterface

// File: rtl/wb_queue.sv
// Writeback queue: arbitrates ALU/load results into a small FIFO and drains
// one entry per cycle onto the register-file write port, publishing a
// per-register pending-write mask for upstream hazard detection.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk1,
  input  logic                     rst,
  wb_queue_if.slave                bus,
  output logic [31:0]              pending,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     idle
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = DEPTH[PW:0];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];

  logic            accept;
  logic            enq;
  logic            deq;
  logic [4:0]      push_rd;
  logic [XLEN-1:0] push_data;
  logic [PW-1:0]   rel;

  // Ready from pre-edge occupancy only; load path has fixed priority.
  always_comb begin
    bus.ld_ready  = !rst && (count != FULL);
    bus.alu_ready = !rst && (count != FULL) && !bus.ld_valid;
    push_rd       = bus.ld_valid ? bus.ld_rd   : bus.alu_rd;
    push_data     = bus.ld_valid ? bus.ld_data : bus.alu_data;
    accept        = (bus.ld_valid && bus.ld_ready) || (bus.alu_valid && bus.alu_ready);
    // Writes to x0 complete the handshake but are never stored.
    enq           = accept && (push_rd != 5'd0);
    deq           = (count != '0);
  end

  // Entry storage; contents are only meaningful inside the occupied window.
  always_ff @(posedge clk1) begin
    if (enq) begin
      q_rd[wr_ptr]   <= push_rd;
      q_data[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and the registered write port.
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      bus.gpr_en   <= 1'b0;
      bus.gpr_addr <= '0;
      bus.gpr_data <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + 1'b1;
      if (deq) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.gpr_addr <= q_rd[rd_ptr];
        bus.gpr_data <= q_data[rd_ptr];
      end
      bus.gpr_en <= deq;
      count      <= count + {{PW{1'b0}}, enq} - {{PW{1'b0}}, deq};
    end
  end

  // Pending mask: every occupied slot (offset from head below count) plus the
  // presented write; x0 is never reported.
  always_comb begin
    pending = '0;
    rel     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      rel = PW'(i) - rd_ptr;
      if ({1'b0, rel} < count) pending[q_rd[i]] = 1'b1;
    end
    if (bus.gpr_en) pending[bus.gpr_addr] = 1'b1;
    pending[0] = 1'b0;
  end

  // Idle when nothing is queued and nothing is being presented.
  always_comb begin
    idle = (count == '0) && !bus.gpr_en;
  end
endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: a queue-based reference model updated on
// each rising edge, a compare process on each falling edge, and directed
// sequences with literal expectations that pin the model.
module tb_wb_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic        clk1 = 1'b0;
  logic        rst  = 1'b1;
  logic [31:0] pending;
  logic [2:0]  count;
  logic        idle;

  wb_queue_if #(.XLEN(XLEN)) bus ();

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk1    (clk1),
    .rst     (rst),
    .bus     (bus),
    .pending (pending),
    .count   (count),
    .idle    (idle)
  );

  always #5 clk1 = ~clk1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue of {rd,data}, plus the output register.
  typedef struct { logic [4:0] rd; logic [31:0] data; } entry_t;
  entry_t      mq[$];
  logic        m_en   = 1'b0;
  logic [4:0]  m_addr = '0;
  logic [31:0] m_data = '0;
  logic [4:0]  wlog[$];

  always @(posedge clk1 or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      int     sz;
      entry_t e;
      bit     take;
      sz   = mq.size();
      take = 1'b0;
      if (bus.ld_valid && sz < DEPTH) begin
        e.rd = bus.ld_rd; e.data = bus.ld_data; take = 1'b1;
      end else if (bus.alu_valid && sz < DEPTH) begin
        e.rd = bus.alu_rd; e.data = bus.alu_data; take = 1'b1;
      end
      if (sz > 0) begin
        entry_t h;
        h = mq.pop_front();
        m_en = 1'b1; m_addr = h.rd; m_data = h.data;
      end else begin
        m_en = 1'b0;
      end
      if (take && e.rd != 5'd0) mq.push_back(e);
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk1) begin
    logic [31:0] mp;
    mp = '0;
    foreach (mq[i]) mp[mq[i].rd] = 1'b1;
    if (m_en) mp[m_addr] = 1'b1;
    mp[0] = 1'b0;
    chk("gpr_en",    bus.gpr_en,    m_en);
    chk("gpr_addr",  bus.gpr_addr,  m_addr);
    chk("gpr_data",  bus.gpr_data,  m_data);
    chk("count",     count,         mq.size());
    chk("pending",   pending,       mp);
    chk("idle",      idle,          (mq.size() == 0) && !m_en);
    chk("ld_ready",  bus.ld_ready,  !rst && mq.size() < DEPTH);
    chk("alu_ready", bus.alu_ready, !rst && mq.size() < DEPTH && !bus.ld_valid);
    if (bus.gpr_en) wlog.push_back(bus.gpr_addr);
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = v; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic set_ld(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.ld_valid = v; bus.ld_rd = rd; bus.ld_data = d;
  endtask

  initial begin
    set_alu(1'b0, 5'd0, '0);
    set_ld(1'b0, 5'd0, '0);
    #1;
    chk("rst_count",   count,         3'd0);
    chk("rst_gpr_en",  bus.gpr_en,    1'b0);
    chk("rst_pending", pending,       32'd0);
    chk("rst_idle",    idle,          1'b1);
    chk("rst_readies", {bus.alu_ready, bus.ld_ready}, 2'b00);
    @(posedge clk1); #3;
    rst = 1'b0;
    step();

    // Single ALU write rd=5, 0xAA.
    set_alu(1'b1, 5'd5, 32'h0000_00AA);
    step();
    set_alu(1'b0, 5'd0, '0);
    @(negedge clk1);
    chk("single_pend_e0", pending, 32'h0000_0020);
    chk("single_en_e0",   bus.gpr_en, 1'b0);
    step();
    @(negedge clk1);
    chk("single_port_e1", {bus.gpr_en, bus.gpr_addr, bus.gpr_data}, {1'b1, 5'd5, 32'h0000_00AA});
    step();
    @(negedge clk1);
    chk("single_done_e2", {bus.gpr_en, pending, idle}, {1'b0, 32'd0, 1'b1});
    step();

    // Priority: load beats ALU in the same cycle.
    set_ld(1'b1, 5'd3, 32'h11);
    set_alu(1'b1, 5'd4, 32'h22);
    @(negedge clk1);
    chk("prio_readies", {bus.ld_ready, bus.alu_ready}, 2'b10);
    step();
    set_ld(1'b0, 5'd0, '0);
    @(negedge clk1);
    chk("prio_alu_rdy", bus.alu_ready, 1'b1);
    step();
    set_alu(1'b0, 5'd0, '0);
    @(negedge clk1);
    chk("prio_port_ld",  {bus.gpr_addr, bus.gpr_data}, {5'd3, 32'h11});
    step();
    @(negedge clk1);
    chk("prio_port_alu", {bus.gpr_en, bus.gpr_addr, bus.gpr_data}, {1'b1, 5'd4, 32'h22});
    step();
    step();

    // Back-to-back burst rd=1..6, pointers wrap.
    wlog.delete();
    for (int i = 1; i <= 6; i++) begin
      set_alu(1'b1, 5'(i), 32'(i * 16));
      step();
    end
    set_alu(1'b0, 5'd0, '0);
    repeat (4) step();
    chk("burst_len", wlog.size(), 6);
    for (int i = 0; i < 6 && i < wlog.size(); i++) chk("burst_order", wlog[i], 5'(i + 1));

    // Load and ALU both offering every cycle.
    wlog.delete();
    set_alu(1'b1, 5'd20, 32'hA0A0);
    for (int i = 0; i < 5; i++) begin
      set_ld(1'b1, 5'(8 + i), 32'(100 + i));
      step();
    end
    set_ld(1'b0, 5'd0, '0);
    step();
    set_alu(1'b0, 5'd0, '0);
    repeat (4) step();
    chk("both_len", wlog.size(), 6);
    if (wlog.size() == 6) chk("both_last", wlog[5], 5'd20);

    // rd=0 result is accepted and dropped.
    wlog.delete();
    set_alu(1'b1, 5'd0, 32'hFFFF_FFFF);
    @(negedge clk1);
    chk("rd0_ready", bus.alu_ready, 1'b1);
    step();
    set_alu(1'b0, 5'd0, '0);
    @(negedge clk1);
    chk("rd0_count", {count, pending}, {3'd0, 32'd0});
    step();
    step();
    chk("rd0_no_write", wlog.size(), 0);

    // Reset mid-operation.
    for (int i = 0; i < 3; i++) begin
      set_ld(1'b1, 5'(7 + i), 32'(200 + i));
      step();
    end
    set_ld(1'b0, 5'd0, '0);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_gpr_en",  bus.gpr_en, 1'b0);
    chk("mrst_count",   count,      3'd0);
    chk("mrst_pending", pending,    32'd0);
    chk("mrst_idle",    idle,       1'b1);
    chk("mrst_readies", {bus.alu_ready, bus.ld_ready}, 2'b00);
    wlog.delete();
    step();
    #2;
    rst = 1'b0;
    repeat (4) step();
    chk("mrst_no_write", wlog.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
